// File: rtl/occ_req_arbiter_if.sv
// Lane-side request/stall bundle plus the shared memory request port.
// The slave modport is the arbiter's view; master is the lanes + memory side.
interface occ_req_arbiter_if #(
  parameter int NUM_LANES = 4,
  parameter int ADDR_W    = 42,
  parameter int TAG_W     = 9,
  parameter int LANE_W    = $clog2(NUM_LANES)
);
  logic [NUM_LANES-1:0]           lane_req_valid;
  logic [NUM_LANES*ADDR_W-1:0]    lane_addr_k;
  logic [NUM_LANES*ADDR_W-1:0]    lane_addr_l;
  logic [NUM_LANES*TAG_W-1:0]     lane_read_num;
  logic [NUM_LANES-1:0]           lane_stall;
  logic                           mem_req_valid;
  logic [ADDR_W-1:0]              mem_req_addr;
  logic [LANE_W+TAG_W+2-1:0]      mem_req_tag;
  logic                           mem_req_ready;
  logic [31:0]                    mem_req_count;

  modport master (
    output lane_req_valid, lane_addr_k, lane_addr_l, lane_read_num, mem_req_ready,
    input  lane_stall, mem_req_valid, mem_req_addr, mem_req_tag, mem_req_count
  );

  modport slave (
    input  lane_req_valid, lane_addr_k, lane_addr_l, lane_read_num, mem_req_ready,
    output lane_stall, mem_req_valid, mem_req_addr, mem_req_tag, mem_req_count
  );
endinterface

// File: rtl/occ_req_arbiter.sv
// Round-robin share of one memory request port: a pair is granted 1 cycle after capture, k/l beats follow.
// Backpressure: a lane is stalled while its pair is held; addr/tag hold steady while mem_req_ready is low.
module occ_req_arbiter #(
  parameter int NUM_LANES = 4,
  parameter int ADDR_W    = 42,
  parameter int TAG_W     = 9,
  parameter int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic               clk,
  input  logic               rst,
  occ_req_arbiter_if.slave   bus
);
  localparam int GTAG_W = LANE_W + TAG_W + 2;

  typedef enum logic [1:0] {IDLE, ISSUE_K, ISSUE_L} state_t;

  state_t                 state;
  logic [NUM_LANES-1:0]   hold_valid;
  logic [ADDR_W-1:0]      hold_k  [NUM_LANES];
  logic [ADDR_W-1:0]      hold_l  [NUM_LANES];
  logic [TAG_W-1:0]       hold_rn [NUM_LANES];
  logic [LANE_W-1:0]      rr_ptr;
  logic [LANE_W-1:0]      grant;
  logic [LANE_W-1:0]      next_ptr;
  logic [ADDR_W-1:0]      req_addr;
  logic [GTAG_W-1:0]      req_tag;
  logic [31:0]            beat_cnt;
  logic                   pick_vld;
  logic [LANE_W-1:0]      pick;
  logic [LANE_W:0]        idx;
  logic                   fire;
  logic                   finish;

  // Scan downward in offset so the lane nearest rr_ptr is the last (winning) assignment.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + (LANE_W+1)'(i);
      if (idx >= (LANE_W+1)'(NUM_LANES))
        idx = idx - (LANE_W+1)'(NUM_LANES);
      if (hold_valid[idx[LANE_W-1:0]]) begin
        pick_vld = 1'b1;
        pick     = idx[LANE_W-1:0];
      end
    end
  end

  assign fire     = bus.mem_req_valid && bus.mem_req_ready;
  assign finish   = fire && ((state == ISSUE_L) || (state == ISSUE_K && req_tag[1:0] == 2'b11));
  assign next_ptr = (grant == LANE_W'(NUM_LANES - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (finish && grant == LANE_W'(i))
          hold_valid[i] <= 1'b0;
        else if (bus.lane_req_valid[i] && !hold_valid[i])
          hold_valid[i] <= 1'b1;
      end
    end
  end

  // Payload needs no reset: it is only read while its hold_valid bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (bus.lane_req_valid[i] && !hold_valid[i]) begin
        hold_k[i]  <= bus.lane_addr_k[i*ADDR_W +: ADDR_W];
        hold_l[i]  <= bus.lane_addr_l[i*ADDR_W +: ADDR_W];
        hold_rn[i] <= bus.lane_read_num[i*TAG_W +: TAG_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      req_addr <= '0;
      req_tag  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant    <= pick;
            req_addr <= hold_k[pick];
            req_tag  <= {pick, hold_rn[pick],
                         (hold_k[pick] == hold_l[pick]) ? 2'b11 : 2'b01};
            state    <= ISSUE_K;
          end
        end
        ISSUE_K: begin
          if (fire) begin
            if (req_tag[1:0] == 2'b11) begin
              rr_ptr <= next_ptr;
              state  <= IDLE;
            end else begin
              req_addr     <= hold_l[grant];
              req_tag[1:0] <= 2'b10;
              state        <= ISSUE_L;
            end
          end
        end
        ISSUE_L: begin
          if (fire) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      beat_cnt <= '0;
    else if (fire)
      beat_cnt <= beat_cnt + 32'd1;
  end

  assign bus.lane_stall    = hold_valid;
  assign bus.mem_req_valid = (state != IDLE);
  assign bus.mem_req_addr  = req_addr;
  assign bus.mem_req_tag   = req_tag;
  assign bus.mem_req_count = beat_cnt;
endmodule

// File: tb/tb_occ_req_arbiter.sv
// Bench for occ_req_arbiter: per-cycle vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_occ_req_arbiter;
  localparam int N  = 4;
  localparam int AW = 42;
  localparam int TW = 9;
  localparam int LW = 2;
  localparam int GW = LW + TW + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  occ_req_arbiter_if #(.NUM_LANES(N), .ADDR_W(AW), .TAG_W(TW)) bus ();
  occ_req_arbiter #(.NUM_LANES(N), .ADDR_W(AW), .TAG_W(TW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit use_model = 1'b0;
  int lane_log[$];

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [GW-1:0] tag;
  } beat_t;

  // Reference model: pending pairs per lane and the beat list of the pair on the port.
  logic [N-1:0]  m_pend;
  logic [AW-1:0] m_k [N];
  logic [AW-1:0] m_l [N];
  logic [TW-1:0] m_r [N];
  int            m_rr;
  int            m_cur;
  beat_t         m_q[$];
  logic [31:0]   m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_rr   = 0;
    m_cur  = 0;
    m_q.delete();
    m_cnt  = '0;
  endtask

  task automatic model_step(input logic [N-1:0] rv, input logic rdy);
    logic [N-1:0] pb;
    bit busy;
    bit found;
    pb    = m_pend;
    busy  = (m_q.size() != 0);
    found = 1'b0;
    if (!busy) begin
      for (int o = 0; o < N; o++) begin
        int l;
        l = (m_rr + o) % N;
        if (!found && pb[l]) begin
          found = 1'b1;
          m_cur = l;
          if (m_k[l] == m_l[l]) begin
            m_q.push_back({m_k[l], LW'(l), m_r[l], 2'b11});
          end else begin
            m_q.push_back({m_k[l], LW'(l), m_r[l], 2'b01});
            m_q.push_back({m_l[l], LW'(l), m_r[l], 2'b10});
          end
        end
      end
    end else if (rdy) begin
      void'(m_q.pop_front());
      m_cnt = m_cnt + 32'd1;
      if (m_q.size() == 0) begin
        m_pend[m_cur] = 1'b0;
        m_rr = (m_cur + 1) % N;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (rv[i] && !pb[i]) begin
        m_pend[i] = 1'b1;
        m_k[i] = bus.lane_addr_k[i*AW +: AW];
        m_l[i] = bus.lane_addr_l[i*AW +: AW];
        m_r[i] = bus.lane_read_num[i*TW +: TW];
      end
    end
  endtask

  task automatic model_check();
    chk("stall", 64'(bus.lane_stall), 64'(m_pend));
    chk("valid", 64'(bus.mem_req_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("addr", 64'(bus.mem_req_addr), 64'(m_q[0].addr));
      chk("tag", 64'(bus.mem_req_tag), 64'(m_q[0].tag));
    end
    chk("count", 64'(bus.mem_req_count), 64'(m_cnt));
  endtask

  task automatic set_lane(input int i, input logic [AW-1:0] k, input logic [AW-1:0] l,
                          input logic [TW-1:0] r);
    bus.lane_addr_k[i*AW +: AW]   = k;
    bus.lane_addr_l[i*AW +: AW]   = l;
    bus.lane_read_num[i*TW +: TW] = r;
  endtask

  // Drive one cycle's inputs, clock it, then sample outputs on the falling edge.
  task automatic cycle(input logic [N-1:0] rv, input logic rdy);
    bus.lane_req_valid = rv;
    bus.mem_req_ready  = rdy;
    if (!rst && bus.mem_req_valid && rdy && bus.mem_req_tag[1:0] != 2'b10)
      lane_log.push_back(int'(bus.mem_req_tag[GW-1 -: LW]));
    @(posedge clk);
    if (rst) model_reset();
    else model_step(rv, rdy);
    @(negedge clk);
    if (use_model) model_check();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle('0, 1'b0);
    cycle('0, 1'b0);
    rst = 1'b0;
    lane_log.delete();
  endtask

  task automatic drain(input string name, input int n, input int budget);
    int c;
    c = 0;
    while ((lane_log.size() < n || bus.lane_stall != '0 || bus.mem_req_valid) && c < budget) begin
      cycle('0, 1'b1);
      c++;
    end
    chk({name, "_done"}, 64'(c < budget), 64'd1);
  endtask

  typedef struct {
    logic [N-1:0]  rv;
    logic          rdy;
    logic [N-1:0]  stall;
    logic          vld;
    logic [AW-1:0] addr;
    logic [GW-1:0] tag;
    logic [31:0]   cnt;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [AW-1:0] a_hold;
    logic [GW-1:0] t_hold;
    logic [N-1:0]  rv;
    logic [AW-1:0] rk;
    rst = 1'b1;
    bus.lane_req_valid = '0;
    bus.lane_addr_k    = '0;
    bus.lane_addr_l    = '0;
    bus.lane_read_num  = '0;
    bus.mem_req_ready  = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    chk("rst_stall", 64'(bus.lane_stall), 64'd0);
    chk("rst_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("rst_addr", 64'(bus.mem_req_addr), 64'd0);
    chk("rst_tag", 64'(bus.mem_req_tag), 64'd0);
    chk("rst_count", 64'(bus.mem_req_count), 64'd0);

    // Lane 0 distinct k/l, then lane 2 with k and l on one line.
    set_lane(0, 42'h100, 42'h180, 9'd5);
    set_lane(2, 42'h240, 42'h240, 9'd7);
    tbl[0] = '{rv: 4'b0001, rdy: 1'b1, stall: 4'b0001, vld: 1'b0, addr: '0,      tag: '0,      cnt: 32'd0};
    tbl[1] = '{rv: 4'b0000, rdy: 1'b1, stall: 4'b0001, vld: 1'b1, addr: 42'h100, tag: 13'h015, cnt: 32'd0};
    tbl[2] = '{rv: 4'b0000, rdy: 1'b1, stall: 4'b0001, vld: 1'b1, addr: 42'h180, tag: 13'h016, cnt: 32'd1};
    tbl[3] = '{rv: 4'b0000, rdy: 1'b1, stall: 4'b0000, vld: 1'b0, addr: '0,      tag: '0,      cnt: 32'd2};
    tbl[4] = '{rv: 4'b0100, rdy: 1'b1, stall: 4'b0100, vld: 1'b0, addr: '0,      tag: '0,      cnt: 32'd2};
    tbl[5] = '{rv: 4'b0000, rdy: 1'b1, stall: 4'b0100, vld: 1'b1, addr: 42'h240, tag: 13'h101F, cnt: 32'd2};
    tbl[6] = '{rv: 4'b0000, rdy: 1'b1, stall: 4'b0000, vld: 1'b0, addr: '0,      tag: '0,      cnt: 32'd3};
    tbl[7] = '{rv: 4'b0000, rdy: 1'b1, stall: 4'b0000, vld: 1'b0, addr: '0,      tag: '0,      cnt: 32'd3};
    for (int v = 0; v < 8; v++) begin
      cycle(tbl[v].rv, tbl[v].rdy);
      chk($sformatf("vec%0d_stall", v), 64'(bus.lane_stall), 64'(tbl[v].stall));
      chk($sformatf("vec%0d_valid", v), 64'(bus.mem_req_valid), 64'(tbl[v].vld));
      chk($sformatf("vec%0d_count", v), 64'(bus.mem_req_count), 64'(tbl[v].cnt));
      if (tbl[v].vld) begin
        chk($sformatf("vec%0d_addr", v), 64'(bus.mem_req_addr), 64'(tbl[v].addr));
        chk($sformatf("vec%0d_tag", v), 64'(bus.mem_req_tag), 64'(tbl[v].tag));
      end
    end

    // All four lanes at once, then lanes 1 and 3 after the round completes.
    do_reset();
    use_model = 1'b1;
    for (int i = 0; i < N; i++)
      set_lane(i, AW'(32'h1000 + 32'(i) * 32'h10), AW'(32'h1008 + 32'(i) * 32'h10), TW'(i + 1));
    cycle(4'b1111, 1'b1);
    drain("rr4", 4, 60);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr4_order%0d", i), 64'(lane_log.size() > i ? lane_log[i] : -1), 64'(i));
    lane_log.delete();
    cycle(4'b1010, 1'b1);
    drain("rr2", 2, 40);
    chk("rr2_first", 64'(lane_log.size() > 0 ? lane_log[0] : -1), 64'd1);
    chk("rr2_second", 64'(lane_log.size() > 1 ? lane_log[1] : -1), 64'd3);

    // Ready held low while the l beat of lane 0 is on the port.
    do_reset();
    cycle(4'b0111, 1'b1);
    cycle('0, 1'b1);
    cycle('0, 1'b1);
    a_hold = bus.mem_req_addr;
    t_hold = bus.mem_req_tag;
    chk("stallL_addr", 64'(a_hold), 64'(42'h1008));
    for (int c = 0; c < 5; c++) begin
      cycle('0, 1'b0);
      chk($sformatf("stallL_addr%0d", c), 64'(bus.mem_req_addr), 64'(a_hold));
      chk($sformatf("stallL_tag%0d", c), 64'(bus.mem_req_tag), 64'(t_hold));
      chk($sformatf("stallL_cnt%0d", c), 64'(bus.mem_req_count), 64'd1);
      chk($sformatf("stallL_held%0d", c), 64'(bus.lane_stall), 64'(4'b0111));
    end
    drain("stallL", 3, 40);
    chk("stallL_total", 64'(bus.mem_req_count), 64'd6);
    chk("stallL_order1", 64'(lane_log.size() > 1 ? lane_log[1] : -1), 64'd1);
    chk("stallL_order2", 64'(lane_log.size() > 2 ? lane_log[2] : -1), 64'd2);

    // Reset while the first beat of a pair is waiting, three lanes held.
    do_reset();
    cycle(4'b1101, 1'b1);
    cycle('0, 1'b0);
    chk("midrst_pre_valid", 64'(bus.mem_req_valid), 64'd1);
    rst = 1'b1;
    cycle('0, 1'b0);
    rst = 1'b0;
    chk("midrst_stall", 64'(bus.lane_stall), 64'd0);
    chk("midrst_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("midrst_count", 64'(bus.mem_req_count), 64'd0);
    lane_log.delete();
    set_lane(1, 42'h3_0000_0000, 42'h3_0000_0040, 9'h1AB);
    cycle(4'b0010, 1'b1);
    drain("midrst_new", 1, 20);
    chk("midrst_new_lane", 64'(lane_log.size() > 0 ? lane_log[0] : -1), 64'd1);
    chk("midrst_new_count", 64'(bus.mem_req_count), 64'd2);

    // Beat counter wrap.
    force dut.beat_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.beat_cnt;
    m_cnt = 32'hFFFF_FFFF;
    chk("wrap_preload", 64'(bus.mem_req_count), 64'hFFFF_FFFF);
    set_lane(3, 42'h55, 42'h55, 9'd9);
    cycle(4'b1000, 1'b1);
    drain("wrap", 1, 20);
    chk("wrap_count", 64'(bus.mem_req_count), 64'd0);

    // Randomized traffic; lanes only issue while not stalled.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rv = '0;
      for (int i = 0; i < N; i++) begin
        if (!m_pend[i] && $urandom_range(0, 3) == 0) begin
          rk = AW'({$urandom(), $urandom()});
          set_lane(i, rk, ($urandom_range(0, 3) == 0) ? rk : AW'({$urandom(), $urandom()}),
                   TW'($urandom()));
          rv[i] = 1'b1;
        end
      end
      cycle(rv, $urandom_range(0, 9) < 7);
    end
    drain("rand", 0, 40);
    chk("rand_count", 64'(bus.mem_req_count), 64'(m_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
